kitchen_timer_ctrl: RTL
=======================

# kitchen_timer_ctrl

Control stage directly upstream of the cascaded down-counter digits in the kitchen timer. It converts the raw start/stop and clear buttons into clean one-cycle presses and divides the system clock into a one-second tick. That tick drives the borrow input of the least-significant digit. It also watches the chain's all-zero flag to stop counting and sound a timed alarm.

## Interface
- PRESCALE, 50000000: clk cycles per tick (1 Hz at 50 MHz); must be ≥ 2.
- ALARM_SECS, 5: alarm duration, in PRESCALE periods.
- BUZZ_DIV, 25000: clk cycles per buzzer half-period (1 kHz at 50 MHz); must be ≥ 1.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- btn_start  in  1  raw start/stop button, active-high, asynchronous to clk.
- btn_clear  in  1  raw clear button, active-high, asynchronous to clk.
- zero  in  1  high when every counter digit reads 0.
- tick  out  1  one-cycle borrow pulse to the least-significant digit.
- digit_clr  out  1  one-cycle pulse that resets the counter digits.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- buzz  out  1  square wave while in ALARM; 0 otherwise.

## Operation
- Button path, per button:
  - Two-flop synchronizer, then a history flop.
  - press = sync2 & ~hist, high for exactly one cycle per rising level.
  - No debounce; upstream glitches produce multiple presses.
- Prescaler:
  - Width $clog2(PRESCALE); counts 0..PRESCALE-1, then wraps to 0.
  - Advances only in RUN; holds its value otherwise.
  - Cleared to 0 on clear press and on entry to RUN from IDLE.
- tick = (state==RUN) & (pre==PRESCALE-1) & ~zero & ~start_press & ~clear_press. It is combinational from registered state.
- States:
  - IDLE:
    - start press with zero=0 → RUN.
    - start press with zero=1 → stays IDLE.
  - RUN:
    - start press → PAUSE.
    - zero=1 sampled → ALARM.
  - PAUSE:
    - start press with zero=0 → RUN; prescaler not cleared, so the partial second is kept.
  - ALARM:
    - Alarm counter counts prescaler-length periods. The prescaler free-runs in ALARM and is cleared on entry.
    - After ALARM_SECS wraps → IDLE.
    - Any start press → IDLE early.
- Clear press from any state → IDLE, with digit_clr=1 for that same cycle. The prescaler, alarm counter and buzzer divider are cleared.
- Priority: reset > clear press > start press > zero > prescaler wrap.
- If a start press in RUN coincides with pre==PRESCALE-1:
  - tick is suppressed and pre holds at PRESCALE-1.
  - tick fires on the first RUN cycle after resume.
- buzz:
  - Toggles every BUZZ_DIV cycles while in ALARM.
  - Forced 0 and divider cleared in every other state.

## Timing
- After reset, every output is 0 and the state is IDLE. The prescaler, alarm counter, buzzer divider and button flops are all 0.
- Button latency:
  - Button level first sampled high at edge k.
  - press is asserted during the cycle after edge k+1.
  - The state changes at edge k+2.
- In RUN from pre=0, the first tick is PRESCALE cycles after RUN entry. Ticks then repeat every PRESCALE cycles.
- zero is expected to rise one cycle after the tick that empties the chain. That cycle has pre=0, so no tick can fire. ALARM is entered at the following edge.
- running and alarm are registered decodes of the state and change on the same edge as the state.
- digit_clr and tick never assert together.
- A reset asserted mid-run returns the block to IDLE at that edge. No tick or digit_clr is emitted in the reset cycle.

## Test plan
- Reset, then PRESCALE=4, zero=0, start press → running=1 three edges after the button rises; tick every 4 cycles, first at pre=3.
- While running, press start on the cycle where pre=3:
  - Expect no tick and running=0.
  - After resume, expect a tick on the first RUN cycle.
- Run with zero asserted one cycle after the 3rd tick, ALARM_SECS=2, BUZZ_DIV=2:
  - alarm=1, running=0.
  - buzz toggles every 2 cycles.
  - alarm falls after 8 cycles.
- Start press in IDLE with zero=1 → state stays IDLE; running stays 0; no ticks.
- Clear press during RUN and simultaneous clear+start in PAUSE → one-cycle digit_clr each time; state IDLE; no tick in the clear cycle.
- Reset asserted during ALARM with buzz=1 → on the next edge alarm=0, buzz=0, running=0; the next start press yields its first tick after a full PRESCALE cycles.

Source files
------------

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen timer control: button synchronisers, one-second prescaler, run/pause/alarm
// sequencing and the alarm buzzer for the cascaded down-counter digits.
module kitchen_timer_ctrl #(
  parameter int PRESCALE   = 50000000,
  parameter int ALARM_SECS = 5,
  parameter int BUZZ_DIV   = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_clear,
  input  logic zero,
  output logic tick,
  output logic digit_clr,
  output logic running,
  output logic alarm,
  output logic buzz
);

  localparam int PW = $clog2(PRESCALE);
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
  localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  logic          start_s1_q, start_s1_d;
  logic          start_s2_q, start_s2_d;
  logic          start_hist_q, start_hist_d;
  logic          clear_s1_q, clear_s1_d;
  logic          clear_s2_q, clear_s2_d;
  logic          clear_hist_q, clear_hist_d;
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] asec_q, asec_d;
  logic [BW-1:0] bdiv_q, bdiv_d;
  logic          buzz_q, buzz_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;

  logic          start_press;
  logic          clear_press;
  logic          pre_wrap;
  logic [PW-1:0] pre_next;

  assign start_press = start_s2_q & ~start_hist_q;
  assign clear_press = clear_s2_q & ~clear_hist_q;
  assign pre_wrap    = (pre_q == PRE_LAST);
  assign pre_next    = pre_wrap ? '0 : pre_q + 1'b1;

  // Gated with reset so neither pulse escapes during the reset cycle.
  assign tick      = ~reset & (state_q == S_RUN) & pre_wrap & ~zero
                     & ~start_press & ~clear_press;
  assign digit_clr = ~reset & clear_press;

  assign running = running_q;
  assign alarm   = alarm_q;
  assign buzz    = buzz_q;

  always_comb begin
    start_s1_d   = btn_start;
    start_s2_d   = start_s1_q;
    start_hist_d = start_s2_q;
    clear_s1_d   = btn_clear;
    clear_s2_d   = clear_s1_q;
    clear_hist_d = clear_s2_q;

    state_d = state_q;
    pre_d   = pre_q;
    asec_d  = asec_q;

    if (clear_press) begin
      state_d = S_IDLE;
      pre_d   = '0;
      asec_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_press && !zero) begin
            state_d = S_RUN;
            pre_d   = '0;
          end
        end
        S_RUN: begin
          // A pause freezes the prescaler so the partial second survives.
          if (start_press) begin
            state_d = S_PAUSE;
          end else if (zero) begin
            state_d = S_ALARM;
            pre_d   = '0;
            asec_d  = '0;
          end else begin
            pre_d = pre_next;
          end
        end
        S_PAUSE: begin
          if (start_press && !zero) begin
            state_d = S_RUN;
          end
        end
        S_ALARM: begin
          if (start_press) begin
            state_d = S_IDLE;
          end else begin
            pre_d = pre_next;
            if (pre_wrap) begin
              if (asec_q == ALARM_LAST) begin
                state_d = S_IDLE;
                asec_d  = '0;
              end else begin
                asec_d = asec_q + 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The buzzer only runs while staying in ALARM; any exit or entry restarts it low.
    if ((state_q == S_ALARM) && (state_d == S_ALARM)) begin
      if (bdiv_q == BUZZ_LAST) begin
        bdiv_d = '0;
        buzz_d = ~buzz_q;
      end else begin
        bdiv_d = bdiv_q + 1'b1;
        buzz_d = buzz_q;
      end
    end else begin
      bdiv_d = '0;
      buzz_d = 1'b0;
    end

    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_hist_q <= 1'b0;
      clear_s1_q   <= 1'b0;
      clear_s2_q   <= 1'b0;
      clear_hist_q <= 1'b0;
      state_q      <= S_IDLE;
      pre_q        <= '0;
      asec_q       <= '0;
      bdiv_q       <= '0;
      buzz_q       <= 1'b0;
      running_q    <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      start_s1_q   <= start_s1_d;
      start_s2_q   <= start_s2_d;
      start_hist_q <= start_hist_d;
      clear_s1_q   <= clear_s1_d;
      clear_s2_q   <= clear_s2_d;
      clear_hist_q <= clear_hist_d;
      state_q      <= state_d;
      pre_q        <= pre_d;
      asec_q       <= asec_d;
      bdiv_q       <= bdiv_d;
      buzz_q       <= buzz_d;
      running_q    <= running_d;
      alarm_q      <= alarm_d;
    end
  end

endmodule
